rle_run_decoder: RTL

// Parametrised run-length decoder: expands a bank of up to N_RUNS run lengths into a 1-bit

---
 rtl/rle_pkg.sv | 17 +
 rtl/rle_run_bank.sv | 44 ++++
 rtl/rle_run_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length decoder.
package rle_pkg;

  localparam int unsigned NRunsDefault = 8;
  localparam int unsigned CntWDefault  = 11;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_t;

  // Runs alternate symbols, so every finished or skipped run flips the symbol.
  function automatic logic next_sym(input logic sym);
    return ~sym;
  endfunction

endpackage

// File: rtl/rle_run_bank.sv
// Descriptor register bank: holds the latched run lengths and the clamped run count,
// and muxes out the length of the run selected by idx.
module rle_run_bank
  import rle_pkg::*;
#(
  parameter int unsigned N_RUNS = NRunsDefault,
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned IDX_W  = $clog2(N_RUNS + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    load,
  input  logic [N_RUNS*CNT_W-1:0] run_lens,
  input  logic [IDX_W-1:0]        run_count,
  input  logic [IDX_W-1:0]        idx,
  output logic [CNT_W-1:0]        cur_len,
  output logic [IDX_W-1:0]        run_cnt
);

  logic [CNT_W-1:0] lens_q [N_RUNS];
  logic [IDX_W-1:0] run_cnt_q;

  // Latch the descriptor on an accepted load; an oversized count is clamped here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < N_RUNS; k++) lens_q[k] <= '0;
      run_cnt_q <= '0;
    end else if (load) begin
      for (int k = 0; k < N_RUNS; k++) lens_q[k] <= run_lens[k*CNT_W +: CNT_W];
      run_cnt_q <= (run_count > IDX_W'(N_RUNS)) ? IDX_W'(N_RUNS) : run_count;
    end
  end

  // Select the current run length; an out-of-range index reads as zero.
  always_comb begin
    cur_len = '0;
    for (int k = 0; k < N_RUNS; k++) begin
      if (idx == IDX_W'(k)) cur_len = lens_q[k];
    end
  end

  assign run_cnt = run_cnt_q;

endmodule

// File: rtl/rle_run_decoder.sv
// Run-length decoder: expands a bank of run lengths into an alternating 1-bit symbol
// stream with valid/ready handshakes on both the descriptor and the output side.
module rle_run_decoder
  import rle_pkg::*;
#(
  parameter int unsigned N_RUNS = NRunsDefault,
  parameter int unsigned CNT_W  = CntWDefault,
  localparam int unsigned IDX_W = $clog2(N_RUNS + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [N_RUNS*CNT_W-1:0] run_lens,
  input  logic [IDX_W-1:0]        run_count,
  input  logic                    first_sym,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sym,
  output logic                    frame_done,
  output logic [IDX_W-1:0]        run_idx
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sym_q, sym_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cur_len;
  logic [IDX_W-1:0] run_cnt;
  logic             load;
  logic             adv;

  assign load_ready = (state_q == IDLE) && !abort;
  assign load       = load_valid && load_ready;

  rle_run_bank #(
    .N_RUNS (N_RUNS),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .load      (load),
    .run_lens  (run_lens),
    .run_count (run_count),
    .idx       (idx_q),
    .cur_len   (cur_len),
    .run_cnt   (run_cnt)
  );

  // Outputs come from registered state only; out_ready never reaches them combinationally.
  assign out_valid  = (state_q == RUN) && (cur_len != '0);
  assign out_sym    = out_valid & sym_q;
  assign frame_done = done_q;
  assign run_idx    = idx_q;

  // Next-state: abort first, then load in IDLE, then beat counting / run skipping in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    adv     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            idx_d = '0;
            cnt_d = '0;
            sym_d = first_sym;
            if (run_count == '0) done_d = 1'b1;
            else                 state_d = RUN;
          end
        end
        RUN: begin
          if (cur_len == '0) begin
            adv = 1'b1;
          end else if (out_ready) begin
            if (cnt_q == cur_len - CNT_W'(1)) begin
              cnt_d = '0;
              adv   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (adv) begin
            if (idx_q == run_cnt - IDX_W'(1)) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              sym_d = next_sym(sym_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
    end
  end

endmodule
